// File: rtl/alu_pkg.sv
// Shared definitions for the sequential EX-stage ALU: opcode map and control FSM states.
package alu_pkg;

    localparam int OP_ADD  = 0;
    localparam int OP_SUB  = 1;
    localparam int OP_AND  = 2;
    localparam int OP_OR   = 3;
    localparam int OP_XOR  = 4;
    localparam int OP_NOR  = 5;
    localparam int OP_SLT  = 6;
    localparam int OP_SLTU = 7;
    localparam int OP_SLL  = 8;
    localparam int OP_SRL  = 9;
    localparam int OP_SRA  = 10;
    localparam int OP_MULU = 11;
    localparam int OP_DIVU = 12;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FIN
    } alu_state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between the multi-cycle control FSM (master) and the ALU (slave).
interface alu_seq_if #(
    parameter int WIDTH = 32,
    parameter int OPW   = 6
) ();

    logic             start;
    logic [OPW-1:0]   opCode;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] ALUout;
    logic [WIDTH-1:0] hi;
    logic             zero;
    logic             ovf;
    logic             busy;
    logic             done;

    modport master (
        output start, opCode, A, B,
        input  ALUout, hi, zero, ovf, busy, done
    );

    modport slave (
        input  start, opCode, A, B,
        output ALUout, hi, zero, ovf, busy, done
    );

endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) / restoring divide, one bit per clock.
// The first step is taken on the accepting edge so WIDTH steps finish in WIDTH cycles;
// done is high in the cycle the final hi/lo values are held.
module alu_muldiv_iter #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    logic             run;
    logic [SHW-1:0]   cnt;
    logic             div_q;
    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic             src_div;
    logic [WIDTH-1:0] src_hi;
    logic [WIDTH-1:0] src_lo;
    logic [WIDTH-1:0] src_m;
    logic [WIDTH-1:0] nxt_hi;
    logic [WIDTH-1:0] nxt_lo;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shl;
    logic [WIDTH:0]   dif;

    // One multiply or divide step; on start it works straight from the fresh operands.
    always_comb begin
        src_div = start ? div : div_q;
        src_hi  = start ? '0  : hi_q;
        src_lo  = start ? a   : lo_q;
        src_m   = start ? b   : m_q;
        sum     = {1'b0, src_hi} + (src_lo[0] ? {1'b0, src_m} : '0);
        shl     = {src_hi, src_lo[WIDTH-1]};
        dif     = shl - {1'b0, src_m};
        nxt_hi  = sum[WIDTH:1];
        nxt_lo  = {sum[0], src_lo[WIDTH-1:1]};
        if (src_div) begin
            // Borrow out of the trial subtraction means the divisor did not fit.
            if (!dif[WIDTH]) begin
                nxt_hi = dif[WIDTH-1:0];
                nxt_lo = {src_lo[WIDTH-2:0], 1'b1};
            end else begin
                nxt_hi = shl[WIDTH-1:0];
                nxt_lo = {src_lo[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Step counter: loaded on start, the cycle where it sits at zero is the done cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            run <= 1'b0;
            cnt <= '0;
        end else if (start) begin
            run <= 1'b1;
            cnt <= SHW'(WIDTH - 1);
        end else if (run) begin
            if (cnt == '0) begin
                run <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Shared accumulator / shift registers and latched divisor-or-multiplicand.
    always_ff @(posedge clk) begin
        if (start || (run && cnt != '0)) begin
            hi_q <= nxt_hi;
            lo_q <= nxt_lo;
        end
        if (start) begin
            m_q   <= b;
            div_q <= div;
        end
    end

    assign done = run && (cnt == '0);
    assign lo   = lo_q;
    assign hi   = hi_q;

endmodule

// File: rtl/alu_seq.sv
// Registered multi-cycle ALU: single-cycle ops land in the output registers on the
// accepting edge; MULU/DIVU hand off to the iterative unit and commit on entering FIN.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OPW   = 6,
    parameter int SHW   = $clog2(WIDTH)
) (
    input logic      clk,
    input logic      reset,
    alu_seq_if.slave bus
);

    function automatic logic [WIDTH-1:0] alu_single(input logic [OPW-1:0] op,
                                                    input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b);
        logic signed [WIDTH-1:0] as;
        logic signed [WIDTH-1:0] bs;
        logic [SHW-1:0]          sh;
        logic [WIDTH-1:0]        r;
        as = a;
        bs = b;
        sh = b[SHW-1:0];
        case (int'(op))
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NOR:  r = ~(a | b);
            OP_SLT:  r = {{(WIDTH-1){1'b0}}, (as < bs)};
            OP_SLTU: r = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLL:  r = a << sh;
            OP_SRL:  r = a >> sh;
            OP_SRA:  r = as >>> sh;
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic add_sub_ovf(input logic [OPW-1:0] op,
                                         input logic [WIDTH-1:0] a,
                                         input logic [WIDTH-1:0] b,
                                         input logic [WIDTH-1:0] r);
        logic o;
        case (int'(op))
            OP_ADD:  o = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            OP_SUB:  o = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            default: o = 1'b0;
        endcase
        return o;
    endfunction

    function automatic logic is_muldiv(input logic [OPW-1:0] op);
        return (int'(op) == OP_MULU) || (int'(op) == OP_DIVU);
    endfunction

    alu_state_t       state;
    alu_state_t       state_n;
    logic             acc_single;
    logic             acc_md;
    logic             commit_md;
    logic             zero_q;
    logic             md_done;
    logic [WIDTH-1:0] md_lo;
    logic [WIDTH-1:0] md_hi;
    logic [WIDTH-1:0] res_single;
    logic             ovf_single;

    assign res_single = alu_single(bus.opCode, bus.A, bus.B);
    assign ovf_single = add_sub_ovf(bus.opCode, bus.A, bus.B, res_single);

    alu_muldiv_iter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_iter (
        .clk   (clk),
        .reset (reset),
        .start (acc_md),
        .div   (int'(bus.opCode) == OP_DIVU),
        .a     (bus.A),
        .b     (bus.B),
        .done  (md_done),
        .lo    (md_lo),
        .hi    (md_hi)
    );

    // Control state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and accept/commit strobes; start is only looked at outside ITER.
    always_comb begin
        state_n    = state;
        acc_single = 1'b0;
        acc_md     = 1'b0;
        commit_md  = 1'b0;
        case (state)
            IDLE, FIN: begin
                state_n = IDLE;
                if (bus.start) begin
                    if (is_muldiv(bus.opCode)) begin
                        acc_md  = 1'b1;
                        state_n = ITER;
                    end else begin
                        acc_single = 1'b1;
                    end
                end
            end
            ITER: begin
                if (md_done) begin
                    commit_md = 1'b1;
                    state_n   = FIN;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Operand equality for a multi-cycle op is held until its result commits.
    always_ff @(posedge clk) begin
        if (acc_md) begin
            zero_q <= (bus.A == bus.B);
        end
    end

    // Result registers: they only move together with a done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.ALUout <= '0;
            bus.hi     <= '0;
            bus.zero   <= 1'b0;
            bus.ovf    <= 1'b0;
            bus.done   <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            if (commit_md) begin
                bus.ALUout <= md_lo;
                bus.hi     <= md_hi;
                bus.zero   <= zero_q;
                bus.ovf    <= 1'b0;
                bus.done   <= 1'b1;
            end else if (acc_single) begin
                bus.ALUout <= res_single;
                bus.hi     <= '0;
                bus.zero   <= (bus.A == bus.B);
                bus.ovf    <= ovf_single;
                bus.done   <= 1'b1;
            end
        end
    end

    assign bus.busy = (state == ITER);

endmodule
